// File: rtl/display7seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display7seg_scan_ctrl
//
// Time-multiplexed scan controller for a 4-digit, 7-segment display.
// Each digit gets a slot of CLK_DIV clocks. The first DEAD_CYCLES clocks of a
// slot keep every digit off to avoid ghosting. Host writes land in shadow
// (pending) registers and are copied to the active registers only at a frame
// boundary, so a frame never shows a mix of old and new data. While scanning
// is disabled, writes take effect immediately.
//
// Optional feature: define DECIMAL_POINT_EN to add per-digit decimal points.
// These follow the same shadow rules and are driven on dp.
//
// Parameters
//   CLK_DIV      clocks per digit slot (>= 2)
//   DEAD_CYCLES  blanking clocks at the start of each slot (0 .. CLK_DIV-1)
//
// Ports
//   clk             system clock, rising edge
//   rst_n           asynchronous reset, active-low
//   enable          1 = scanning, 0 = display off and scan position cleared
//   digits[15:0]    hex value per digit, digit0 = [3:0] ... digit3 = [15:12]
//   blank_mask[3:0] bit i = 1 keeps digit i dark for its whole slot
//   load            1-cycle strobe that captures digits/blank_mask
//   decimal_points  (DECIMAL_POINT_EN only) bit i = 1 lights the dp of digit i
//   anode[3:0]      digit select, active-low (one-cold or all ones)
//   segments[6:0]   {g,f,e,d,c,b,a}, active-low
//   dp              (DECIMAL_POINT_EN only) decimal point, active-low
//   frame_done      1-cycle pulse after each frame boundary
// -----------------------------------------------------------------------------
module display7seg_scan_ctrl #(
  parameter int CLK_DIV     = 1000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] digits,
  input  logic [3:0]  blank_mask,
  input  logic        load,
`ifdef DECIMAL_POINT_EN
  input  logic [3:0]  decimal_points,
`endif
  output logic [3:0]  anode,
  output logic [6:0]  segments,
`ifdef DECIMAL_POINT_EN
  output logic        dp,
`endif
  output logic        frame_done
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  typedef enum logic {
    PH_DEAD,
    PH_ON
  } phase_t;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       slot;

  logic [15:0]      act_digits;
  logic [3:0]       act_blank;
  logic [15:0]      pend_digits;
  logic [3:0]       pend_blank;
  logic             pend_valid;
`ifdef DECIMAL_POINT_EN
  logic [3:0]       act_dp;
  logic [3:0]       pend_dp;
  logic             dp_nxt;
`endif

  phase_t           phase;
  logic             wrap;
  logic             boundary;
  logic             apply_now;
  logic [3:0]       anode_nxt;
  logic [6:0]       seg_nxt;

  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    wrap      = (cnt == CNT_MAX);
    boundary  = wrap && (slot == 2'd3);
    // Shadow data moves to the active set at a frame boundary, or at once
    // while the display is off (there is no frame to tear).
    apply_now = !enable || boundary;
    phase     = (int'(cnt) < DEAD_CYCLES) ? PH_DEAD : PH_ON;

    anode_nxt = 4'b1111;
    seg_nxt   = 7'h7F;
`ifdef DECIMAL_POINT_EN
    dp_nxt    = 1'b1;
`endif
    if (enable && (phase == PH_ON) && !act_blank[slot]) begin
      anode_nxt = ~(4'b0001 << slot);
      seg_nxt   = hex7seg(act_digits[{slot, 2'b00} +: 4]);
`ifdef DECIMAL_POINT_EN
      dp_nxt    = ~act_dp[slot];
`endif
    end
  end

  // NOTE: state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the pending shadow registers are reset as well; they are only a
  // few flops and a defined value keeps the block fully deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      slot        <= '0;
      act_digits  <= '0;
      act_blank   <= 4'b1111;
      pend_digits <= '0;
      pend_blank  <= '0;
      pend_valid  <= 1'b0;
      anode       <= 4'b1111;
      segments    <= 7'h7F;
      frame_done  <= 1'b0;
`ifdef DECIMAL_POINT_EN
      act_dp      <= '0;
      pend_dp     <= '0;
      dp          <= 1'b1;
`endif
    end else begin
      // Outputs reflect the pre-edge position and active data (one cycle late).
      anode      <= anode_nxt;
      segments   <= seg_nxt;
      frame_done <= enable && boundary;
`ifdef DECIMAL_POINT_EN
      dp         <= dp_nxt;
`endif

      if (!enable) begin
        cnt  <= '0;
        slot <= '0;
      end else if (wrap) begin
        cnt  <= '0;
        slot <= slot + 2'd1;
      end else begin
        cnt  <= cnt + 1'b1;
      end

      if (apply_now) begin
        // A Load on the applying edge bypasses the pending registers.
        if (load) begin
          act_digits <= digits;
          act_blank  <= blank_mask;
`ifdef DECIMAL_POINT_EN
          act_dp     <= decimal_points;
`endif
        end else if (pend_valid) begin
          act_digits <= pend_digits;
          act_blank  <= pend_blank;
`ifdef DECIMAL_POINT_EN
          act_dp     <= pend_dp;
`endif
        end
        pend_valid <= 1'b0;
      end else if (load) begin
        pend_digits <= digits;
        pend_blank  <= blank_mask;
`ifdef DECIMAL_POINT_EN
        pend_dp     <= decimal_points;
`endif
        pend_valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display7seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display7seg_scan_ctrl
//
// Self-checking bench for display7seg_scan_ctrl with CLK_DIV=8, DEAD_CYCLES=2.
// A behavioural model tracks the position inside a 32-cycle frame as a plain
// integer and derives slot/phase by division. A compare process checks every
// output on every falling edge. A directed sequence pins the model with
// hand-computed literals. A randomized phase then follows.
// -----------------------------------------------------------------------------
module tb_display7seg_scan_ctrl;

  localparam int CLK_DIV = 8;
  localparam int DEAD    = 2;
  localparam int FRAME   = 4 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  blank_mask = '0;
  logic        load = 1'b0;
  logic [3:0]  anode;
  logic [6:0]  segments;
  logic        frame_done;

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  display7seg_scan_ctrl #(
    .CLK_DIV    (CLK_DIV),
    .DEAD_CYCLES(DEAD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .digits     (digits),
    .blank_mask (blank_mask),
    .load       (load),
    .anode      (anode),
    .segments   (segments),
    .frame_done (frame_done)
  );

  // ---------------- behavioural model ----------------
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int          m_pos = 0;
  logic [15:0] m_dig = '0;
  logic [3:0]  m_blk = 4'b1111;
  logic [15:0] p_dig = '0;
  logic [3:0]  p_blk = '0;
  bit          m_pend = 1'b0;
  logic [3:0]  e_an = 4'b1111;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_fd = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos  = 0;
      m_dig  = '0;
      m_blk  = 4'b1111;
      m_pend = 1'b0;
      e_an   = 4'b1111;
      e_seg  = 7'h7F;
      e_fd   = 1'b0;
    end else begin
      int sl;
      int ct;
      sl = m_pos / CLK_DIV;
      ct = m_pos % CLK_DIV;
      if (enable && ct >= DEAD && !m_blk[sl]) begin
        e_an  = ~(4'b0001 << sl);
        e_seg = hex_tab[m_dig[sl*4 +: 4]];
      end else begin
        e_an  = 4'b1111;
        e_seg = 7'h7F;
      end
      e_fd = enable && (m_pos == FRAME - 1);

      if (!enable || m_pos == FRAME - 1) begin
        if (load) begin
          m_dig = digits;
          m_blk = blank_mask;
        end else if (m_pend) begin
          m_dig = p_dig;
          m_blk = p_blk;
        end
        m_pend = 1'b0;
      end else if (load) begin
        p_dig  = digits;
        p_blk  = blank_mask;
        m_pend = 1'b1;
      end
      m_pos = enable ? (m_pos + 1) % FRAME : 0;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      check("model_anode", 32'(anode), 32'(e_an));
      check("model_segments", 32'(segments), 32'(e_seg));
      check("model_frame_done", 32'(frame_done), 32'(e_fd));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pin(input string name, input logic [3:0] an, input logic [6:0] sg);
    check({name, "_anode"}, 32'(anode), 32'(an));
    check({name, "_segments"}, 32'(segments), 32'(sg));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tick(3);
    cmp_on = 1'b1;
    pin("reset", 4'b1111, 7'h7F);
    check("reset_frame_done", 32'(frame_done), 32'h0);

    // Scan with no data loaded: dark, FrameDone every 32 cycles.
    rst_n  = 1'b1;
    enable = 1'b1;
    tick(31);
    check("fd_edge31", 32'(frame_done), 32'h0);
    tick(1);
    check("fd_edge32", 32'(frame_done), 32'h1);
    tick(1);
    check("fd_edge33", 32'(frame_done), 32'h0);
    tick(2);
    pin("dark_no_load", 4'b1111, 7'h7F);

    // Load 3210 mid-frame; visible from the next frame.
    digits = 16'h3210; blank_mask = 4'b0000; load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(28);
    pin("before_boundary", 4'b1111, 7'h7F);
    check("fd_edge64", 32'(frame_done), 32'h1);
    tick(3);  pin("d0_3210", 4'b1110, 7'h40);
    tick(8);  pin("d1_3210", 4'b1101, 7'h79);
    tick(8);  pin("d2_3210", 4'b1011, 7'h24);
    tick(8);  pin("d3_3210", 4'b0111, 7'h30);
    tick(6);  pin("dead_slot0", 4'b1111, 7'h7F);

    // Load ABCD during slot 1: old data stays until the boundary.
    tick(8);
    digits = 16'hABCD; load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(1);  pin("old_during_frame", 4'b1101, 7'h79);
    tick(21);
    tick(3);  pin("d0_abcd", 4'b1110, 7'h21);
    tick(8);  pin("d1_abcd", 4'b1101, 7'h46);
    tick(8);  pin("d2_abcd", 4'b1011, 7'h03);
    tick(8);  pin("d3_abcd", 4'b0111, 7'h08);

    // Two loads before one boundary: last wins.
    digits = 16'h1111; load = 1'b1;
    tick(1);
    digits = 16'h8888;
    tick(1);
    load = 1'b0;
    tick(3);
    tick(3);  pin("last_load_d0", 4'b1110, 7'h00);
    tick(24); pin("last_load_d3", 4'b0111, 7'h00);

    // Blank digits 1 and 3.
    digits = 16'h3210; blank_mask = 4'b1010; load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(4);
    tick(3);  pin("blank_d0", 4'b1110, 7'h40);
    tick(8);  pin("blank_d1", 4'b1111, 7'h7F);
    tick(8);  pin("blank_d2", 4'b1011, 7'h24);
    tick(8);  pin("blank_d3", 4'b1111, 7'h7F);

    // Asynchronous reset during slot 2 ON.
    tick(24); pin("pre_reset_d2", 4'b1011, 7'h24);
    #2 rst_n = 1'b0;
    #1 pin("async_reset", 4'b1111, 7'h7F);
    check("async_reset_fd", 32'(frame_done), 32'h0);
    @(negedge clk);

    // Load while disabled applies at once; enable restarts at slot 0.
    rst_n = 1'b1; enable = 1'b0;
    digits = 16'h3210; blank_mask = 4'b0000; load = 1'b1;
    tick(1);
    load = 1'b0; enable = 1'b1;
    tick(2);  pin("restart_dead", 4'b1111, 7'h7F);
    tick(1);  pin("restart_on", 4'b1110, 7'h40);
    tick(5);  pin("slot0_late", 4'b1110, 7'h40);
    enable = 1'b0;
    tick(1);  pin("disable_dark", 4'b1111, 7'h7F);
    check("disable_fd", 32'(frame_done), 32'h0);
    tick(3);
    enable = 1'b1;
    tick(2);  pin("reenable_dead", 4'b1111, 7'h7F);
    tick(1);  pin("reenable_on", 4'b1110, 7'h40);

    // Randomized phase, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      enable     = ($urandom_range(0, 99) < 93);
      load       = ($urandom_range(0, 99) < 6);
      digits     = 16'($urandom);
      blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 799) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
      @(negedge clk);
    end
    load = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
